booth_controller: RTL

//  - FSM sequencing the 6-bit radix-2 Booth multiplier datapath: loads X then Y from the shared
//    6-bit inBus, runs WIDTH add/sub-then-shift iterations driven by Y0Yminus1, then drives the
//    12-bit product onto outBus as two words: A (high), then Y (low).
//  - Sits beside the datapath in the multiplier top; it is the only driver of the datapath controls.

---
 rtl/booth_pkg.sv | 25 ++
 rtl/booth_iter_counter.sv | 38 +++
 rtl/booth_controller.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
//  Shared definitions for the radix-2 Booth multiplier controller:
//   - state_t      : controller state encoding (3 bits, one spare code)
//   - BOOTH_ADD/SUB: {Y[0], Y[-1]} codes that need an add or a subtract
//   - WIDTH_DEF    : default operand width (= number of Booth iterations)
// ---------------------------------------------------------------------------
package booth_pkg;

   localparam int WIDTH_DEF = 6;

   localparam logic [1:0] BOOTH_ADD = 2'b01;  // A <= A + X
   localparam logic [1:0] BOOTH_SUB = 2'b10;  // A <= A - X

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LDX    = 3'd1,
      ST_LDY    = 3'd2,
      ST_ADD    = 3'd3,
      ST_SHIFT  = 3'd4,
      ST_OUT_HI = 3'd5,
      ST_OUT_LO = 3'd6
   } state_t;

endpackage

// File: rtl/booth_iter_counter.sv
// ---------------------------------------------------------------------------
// booth_iter_counter
//  Counts completed Booth iterations.
//  Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-low reset
//   clr   in  restart the count at zero (operand load)
//   inc   in  advance the count by one (shift of a non-final iteration)
//   last  out count has reached WIDTH-1, i.e. the current iteration is the final one
// ---------------------------------------------------------------------------
module booth_iter_counter #(
   parameter int WIDTH = 6,
   parameter int CNT_W = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic last
);

   logic [CNT_W-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign last = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_controller.sv
// ---------------------------------------------------------------------------
// booth_controller
//  Sequencer for a radix-2 Booth multiplier datapath: loads X then Y from the
//  shared input bus, runs WIDTH add/sub-then-shift iterations steered by
//  {Y[0], Y[-1]}, then presents the product as two words (A, then Y).
//  Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   start                    operation request, honoured only in IDLE
//   Y0Yminus1                {Y[0], Y[-1]} from the datapath
//   ready                    controller idle
//   ldX, ldY, ldA            datapath register loads
//   initA, initYminusOne     clear A / clear Y[-1]
//   aBarS                    adder select (0: A+X, 1: A-X)
//   shRA, shRY, ldYminusOne  iteration shift controls (same edge)
//   selL, selR               bus enables for A / Y (mutually exclusive)
//   outValid, done           product word valid; done marks the low word
// ---------------------------------------------------------------------------
module booth_controller
   import booth_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] Y0Yminus1,
   output logic       ready,
   output logic       ldX,
   output logic       ldY,
   output logic       ldA,
   output logic       initA,
   output logic       initYminusOne,
   output logic       aBarS,
   output logic       shRA,
   output logic       shRY,
   output logic       ldYminusOne,
   output logic       selL,
   output logic       selR,
   output logic       outValid,
   output logic       done
);

   state_t r_state;
   state_t w_next;
   logic   w_last;
   logic   w_cnt_clr;
   logic   w_cnt_inc;

   booth_iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_cnt_clr),
      .inc  (w_cnt_inc),
      .last (w_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // NOTE: every signal driven here gets a default before the case so no
   // path leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next        = ST_IDLE;
      w_cnt_clr     = 1'b0;
      w_cnt_inc     = 1'b0;
      ready         = 1'b0;
      ldX           = 1'b0;
      ldY           = 1'b0;
      ldA           = 1'b0;
      initA         = 1'b0;
      initYminusOne = 1'b0;
      aBarS         = 1'b0;
      shRA          = 1'b0;
      shRY          = 1'b0;
      ldYminusOne   = 1'b0;
      selL          = 1'b0;
      selR          = 1'b0;
      outValid      = 1'b0;
      done          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            ready  = 1'b1;
            w_next = start ? ST_LDX : ST_IDLE;
         end
         ST_LDX: begin
            ldX    = 1'b1;
            w_next = ST_LDY;
         end
         ST_LDY: begin
            ldY           = 1'b1;
            initA         = 1'b1;
            initYminusOne = 1'b1;
            w_cnt_clr     = 1'b1;
            w_next        = ST_ADD;
         end
         ST_ADD: begin
            // Only the 01/10 Booth codes touch A; 00/11 just fall through to the shift.
            if (Y0Yminus1 == BOOTH_SUB) begin
               ldA   = 1'b1;
               aBarS = 1'b1;
            end else if (Y0Yminus1 == BOOTH_ADD) begin
               ldA   = 1'b1;
            end
            w_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            shRA        = 1'b1;
            shRY        = 1'b1;
            ldYminusOne = 1'b1;
            if (w_last) begin
               w_next = ST_OUT_HI;
            end else begin
               w_cnt_inc = 1'b1;
               w_next    = ST_ADD;
            end
         end
         ST_OUT_HI: begin
            selL     = 1'b1;
            outValid = 1'b1;
            w_next   = ST_OUT_LO;
         end
         ST_OUT_LO: begin
            selR     = 1'b1;
            outValid = 1'b1;
            done     = 1'b1;
            w_next   = ST_IDLE;
         end
         default: begin
            // Spare encoding: outputs stay at their all-zero defaults, recover to IDLE.
            w_next = ST_IDLE;
         end
      endcase
   end

endmodule
